nn_layer_activation_server: RTL and testbench

//  Responder end of the layer input read channel (trig/abus/dbus). A layer drives it with a

---
 rtl/nn_layer_activation_server.sv | 175 +++++++++++++++++
 tb/tb_nn_layer_activation_server.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nn_layer_activation_server.sv
// -----------------------------------------------------------------------------
// nn_layer_activation_server
//
// Purpose:
//   Ping-pong activation buffer between two neural-network layers. The
//   producing layer writes activations into the fill bank and commits it; the
//   consuming layer sees req_out, reads the read bank over the trig/abus/dbus
//   read channel (data one cycle after the trigger) and releases the bank
//   with ack_in.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   wr_trig    producer write strobe
//   wr_addr    write address within the fill bank
//   wr_data    signed write data
//   wr_commit  fill bank complete, hand it to the consumer
//   wr_ready   a fill bank is free
//   rd_trig    consumer read strobe
//   rd_addr    consumer read address (unused when auto-increment is built)
//   rd_data    registered signed read data
//   rd_valid   one-cycle pulse qualifying rd_data
//   req_out    a committed bank is available
//   ack_in     consumer done with the read bank
//   err_drop   sticky: a write or commit was dropped while both banks were full
//
// Configuration:
//   ACT_RD_AUTOINC_EN  when defined, rd_addr is ignored and an internal
//                      pointer (step 1 per accepted read, wrap at DEPTH-1,
//                      cleared on rst and on an accepted ack_in) supplies the
//                      read address.
// -----------------------------------------------------------------------------
module nn_layer_activation_server #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_trig,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     wr_commit,
  output logic                     wr_ready,
  input  logic                     rd_trig,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     req_out,
  input  logic                     ack_in,
  output logic                     err_drop
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  // True when an address falls inside a bank.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH_U);
  endfunction

  logic signed [DATA_W-1:0] mem_q [2][DEPTH];

  logic                     wb_q, wb_d;
  logic                     rb_q, rb_d;
  logic [1:0]               cnt_q, cnt_d;
  logic signed [DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     err_q, err_d;

  logic              commit_acc_s;
  logic              rel_acc_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [ADDR_W-1:0] rd_addr_s;

  assign wr_ready = (cnt_q != 2'd2);
  assign req_out  = (cnt_q != 2'd0);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err_drop = err_q;

`ifdef ACT_RD_AUTOINC_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Read pointer: clear on release (release wins over a same-cycle read), else step and wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (rel_acc_s) begin
      ptr_d = ADDR_W'(0);
    end else if (rd_acc_s) begin
      if (ptr_q == ADDR_W'(DEPTH - 1)) begin
        ptr_d = ADDR_W'(0);
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Read pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ADDR_W'(0);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign rd_addr_s = ptr_q;
`else
  assign rd_addr_s = rd_addr;
`endif

  // Handshake decode and next-state for bank pointers, occupancy, read port and error flag.
  always_comb begin
    commit_acc_s = wr_commit & wr_ready;
    rel_acc_s    = ack_in & req_out;
    wr_acc_s     = wr_trig & wr_ready & addr_ok(wr_addr);
    rd_acc_s     = rd_trig & req_out & addr_ok(rd_addr_s);

    wb_d       = commit_acc_s ? ~wb_q : wb_q;
    rb_d       = rel_acc_s ? ~rb_q : rb_q;
    err_d      = err_q | ((wr_trig | wr_commit) & ~wr_ready);
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    // Simultaneous commit and release leaves the occupancy unchanged.
    case ({commit_acc_s, rel_acc_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // A read uses the current rb, so a same-cycle ack_in still reads the old bank.
    if (rd_acc_s) begin
      rd_data_d  = mem_q[rb_q][rd_addr_s];
      rd_valid_d = 1'b1;
    end else if (rd_trig) begin
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
    end else begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      cnt_q      <= 2'd0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Activation storage; contents deliberately survive reset. Writes use the
  // pre-commit wb, so a same-cycle write lands in the bank being committed.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wb_q][wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_nn_layer_activation_server.sv
// -----------------------------------------------------------------------------
// tb_nn_layer_activation_server
//
// Purpose:
//   Directed self-checking bench for nn_layer_activation_server with
//   DATA_W=8, DEPTH=2, ADDR_W=1. Inputs change 1 time unit after each rising
//   edge; outputs are checked at the same point, after the edge has settled.
//   Covers ACT_RD_AUTOINC_EN when that macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_nn_layer_activation_server;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_trig;
  logic [0:0]        wr_addr;
  logic signed [7:0] wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd_trig;
  logic [0:0]        rd_addr;
  logic signed [7:0] rd_data;
  logic              rd_valid;
  logic              req_out;
  logic              ack_in;
  logic              err_drop;

  int checks = 0;
  int errors = 0;

  nn_layer_activation_server #(.DATA_W(8), .DEPTH(2), .ADDR_W(1)) dut (
    .clk(clk), .rst(rst),
    .wr_trig(wr_trig), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready(wr_ready),
    .rd_trig(rd_trig), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .req_out(req_out), .ack_in(ack_in), .err_drop(err_drop)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_trig = 1'b0; wr_commit = 1'b0; rd_trig = 1'b0; ack_in = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [0:0] a, input logic signed [7:0] d);
    idle(); wr_trig = 1'b1; wr_addr = a; wr_data = d; tick(); idle();
  endtask

  task automatic commit();
    idle(); wr_commit = 1'b1; tick(); idle();
  endtask

  task automatic ack();
    idle(); ack_in = 1'b1; tick(); idle();
  endtask

  task automatic rd(input logic [0:0] a);
    idle(); rd_trig = 1'b1; rd_addr = a; tick(); idle();
  endtask

  initial begin
    rst = 1'b1; wr_addr = 1'b0; wr_data = 8'sd0; rd_addr = 1'b0;
    idle();
    tick(); tick();
    check("rst_req_out", req_out, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'sd0);
    check("rst_err_drop", err_drop, 1'b0);
    rst = 1'b0;
    tick();

`ifdef ACT_RD_AUTOINC_EN
    // Auto-increment: 15,78,15 then restart at 0 after release.
    wr(1'b0, 8'sd15); wr(1'b1, 8'sd78); commit();
    check("ai_req_out", req_out, 1'b1);
    rd(1'b1); check("ai_rd0", rd_data, 8'sd15); check("ai_v0", rd_valid, 1'b1);
    rd(1'b0); check("ai_rd1", rd_data, 8'sd78);
    rd(1'b1); check("ai_rd2", rd_data, 8'sd15);
    ack();
    check("ai_ack_req", req_out, 1'b0);
    wr(1'b0, 8'sd40); wr(1'b1, 8'sd50); commit();
    rd(1'b1); check("ai_restart", rd_data, 8'sd40);
    rd(1'b1); check("ai_next", rd_data, 8'sd50);
`else
    // 1: basic write, commit, read with one-cycle latency.
    wr(1'b0, 8'sd15); wr(1'b1, 8'sd78);
    check("t1_req_pre", req_out, 1'b0);
    commit();
    check("t1_req_out", req_out, 1'b1);
    rd(1'b1);
    check("t1_rd_data", rd_data, 8'sd78);
    check("t1_rd_valid", rd_valid, 1'b1);
    tick();
    check("t1_valid_pulse", rd_valid, 1'b0);
    ack();
    check("t1_ack_req", req_out, 1'b0);

    // 2: both banks committed, full; release then read second bank back-to-back.
    wr(1'b0, 8'sd7); wr(1'b1, 8'sd7); commit();
    wr(1'b0, 8'sd39); wr(1'b1, -8'sd39); commit();
    check("t2_full_ready", wr_ready, 1'b0);
    check("t2_full_req", req_out, 1'b1);
    rd(1'b1); check("t2_rd_first", rd_data, 8'sd7);
    ack();
    check("t2_ready_again", wr_ready, 1'b1);
    check("t2_req_b2b", req_out, 1'b1);
    idle(); rd_trig = 1'b1; rd_addr = 1'b0; tick();
    check("t2_rd_39", rd_data, 8'sd39);
    rd_addr = 1'b1; tick();
    check("t2_rd_m39", rd_data, -8'sd39);
    check("t2_b2b_valid", rd_valid, 1'b1);
    idle();

    // 3: fill to full, then a dropped write sets err_drop and does not land.
    wr(1'b0, 8'sd5); wr(1'b1, 8'sd6); commit();
    check("t3_full", wr_ready, 1'b0);
    wr(1'b0, 8'sd100);
    check("t3_err_drop", err_drop, 1'b1);
    rd(1'b0); check("t3_unchanged", rd_data, 8'sd39);
    commit();
    check("t3_commit_dropped", wr_ready, 1'b0);
    tick();
    check("t3_err_sticky", err_drop, 1'b1);

    // 4: occupancy 1, commit + ack + read in one cycle.
    ack();
    check("t4_cnt1_ready", wr_ready, 1'b1);
    wr(1'b0, 8'sd11); wr(1'b1, 8'sd22);
    idle(); wr_commit = 1'b1; ack_in = 1'b1; rd_trig = 1'b1; rd_addr = 1'b0; tick(); idle();
    check("t4_req_stays", req_out, 1'b1);
    check("t4_ready_stays", wr_ready, 1'b1);
    check("t4_old_rb_read", rd_data, 8'sd5);
    rd(1'b0); check("t4_new_bank0", rd_data, 8'sd11);
    rd(1'b1); check("t4_new_bank1", rd_data, 8'sd22);

    // Empty-queue behaviour: read returns 0/invalid, ack ignored.
    ack();
    check("t4_empty_req", req_out, 1'b0);
    rd(1'b1);
    check("t4_empty_rd_data", rd_data, 8'sd0);
    check("t4_empty_rd_valid", rd_valid, 1'b0);
    ack();
    check("t4_ack_ignored_ready", wr_ready, 1'b1);
    commit();
    rd(1'b1); check("t4_ack_ignored_rb", rd_data, 8'sd6);

    // 5: reset in the middle of a read discards everything and clears err_drop.
    wr(1'b0, 8'sd15); wr(1'b1, 8'sd78); commit();
    check("t5_full", wr_ready, 1'b0);
    idle(); rd_trig = 1'b1; rd_addr = 1'b0; rst = 1'b1; tick(); idle(); rst = 1'b0;
    check("t5_req_out", req_out, 1'b0);
    check("t5_wr_ready", wr_ready, 1'b1);
    check("t5_rd_valid", rd_valid, 1'b0);
    check("t5_rd_data", rd_data, 8'sd0);
    check("t5_err_drop", err_drop, 1'b0);
    // Storage is not reset; an empty commit exposes the old bank-0 contents.
    commit();
    rd(1'b0); check("t5_mem_kept", rd_data, 8'sd15);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
